// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage
// ----------------------------------------------------------------------------
// Instruction fetch stage. It issues one word fetch at a time to instruction
// memory, tags each response with the PC it was fetched from, and buffers the
// {instruction, pc} pairs in a small FIFO that feeds decode. Branch and jump
// redirects flush the FIFO and discard any fetch still in flight.
//
// Parameters
//   QDEPTH          fetch-queue entries (2 or 4)
//
// Ports
//   clk             clock, all state changes on the rising edge
//   reset_n         asynchronous active-low reset
//   pc_cur          current PC from the external PC register
//   pc_next         next-PC value for the PC register input
//   pc_en           PC register load enable
//   imem_req        fetch request (only with credit and no redirect)
//   imem_addr       word-aligned fetch address
//   imem_gnt        memory accepted the request this cycle
//   imem_rvalid     fetch response valid
//   imem_rdata      fetch response data
//   redirect_valid  branch/jump redirect this cycle
//   redirect_pc     redirect target
//   id_valid        queue head valid to decode
//   id_instr        queue head instruction
//   id_pc           queue head PC
//   id_ready        decode accepts the queue head
//   fetch_stall_cnt (only with IF_FETCH_PERF_EN) saturating count of cycles
//                   where decode was ready but no instruction was available
//
// Optional feature macro: IF_FETCH_PERF_EN
// ============================================================================
module if_fetch_stage #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;  // no fetch outstanding
    localparam logic [1:0] ST_WAIT  = 2'd1;  // one fetch outstanding
    localparam logic [1:0] ST_DRAIN = 2'd2;  // outstanding fetch will be dropped

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      tag;

    logic [31:0]      instr_mem [QDEPTH];
    logic [31:0]      pc_mem    [QDEPTH];

    logic             outstanding;
    logic             credit_ok;
    logic             grant;
    logic             push;
    logic             pop;

    // ------------------------------------------------------------------------
    // Request / PC control
    // ------------------------------------------------------------------------
    assign outstanding = (state != ST_IDLE);

    // A request is only made when the queue is guaranteed to have room for
    // its response, so pushes can never overflow.
    assign credit_ok = (count + CNT_W'(outstanding)) < CNT_W'(QDEPTH);

    // reset_n gates the combinational outputs so that request and PC enable
    // drop the instant reset asserts, not at the next clock edge.
    assign imem_req  = reset_n && (state == ST_IDLE) && !redirect_valid && credit_ok;
    assign imem_addr = {pc_cur[31:2], 2'b00};
    assign grant     = imem_req && imem_gnt;

    assign pc_en   = reset_n && (redirect_valid || grant);
    assign pc_next = redirect_valid ? redirect_pc : (pc_cur + 32'd4);

    // ------------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------------
    // Responses arriving in IDLE (stray) or DRAIN (stale) are never pushed,
    // and a redirect in the same cycle discards the response as well.
    assign push = (state == ST_WAIT) && imem_rvalid && !redirect_valid;
    // Flush takes priority over a decode handshake in the same cycle.
    assign pop  = id_valid && id_ready && !redirect_valid;

    assign id_instr = instr_mem[rd_ptr];
    assign id_pc    = pc_mem[rd_ptr];

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A response coinciding with a redirect is simply dropped, so
                // nothing is left outstanding and we return to IDLE.
                if (imem_rvalid)         state_nxt = ST_IDLE;
                else if (redirect_valid) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The stale response retires the outstanding fetch even if
                // another redirect arrives in the same cycle; staying in DRAIN
                // then would wait forever for a response that already came.
                if (imem_rvalid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (redirect_valid)     count_nxt = '0;
        else if (push && !pop)  count_nxt = count + CNT_W'(1);
        else if (pop && !push)  count_nxt = count - CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag      <= '0;
            id_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            // Registered copy of (count != 0) for a glitch-free valid.
            id_valid <= (count_nxt != '0);
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (grant) tag <= pc_cur;
        end
    end

    // NOTE: the queue storage has no reset; entries are only visible through
    // id_valid, which is reset, so clearing the array would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= tag;
        end
    end

`ifdef IF_FETCH_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counter: decode starved cycles, saturating.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_stall_cnt <= '0;
        end else if (id_ready && !id_valid && (fetch_stall_cnt != 32'hFFFF_FFFF)) begin
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter QDEPTH, 2, fetch-queue entries; legal values 2 or 4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pc_cur  input  32  current PC from the PC register.
REQ-005 SHALL have port pc_next  output  32  next-PC value to the PC register input.
REQ-006 SHALL have port pc_en  output  1  PC register enable.
REQ-007 SHALL have ports imem_req  output  1 and imem_addr  output  32  fetch request and word address.
REQ-008 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-009 SHALL have ports imem_rvalid  input  1 and imem_rdata  input  32  fetch response.
REQ-010 SHALL have ports redirect_valid  input  1 and redirect_pc  input  32  branch/jump redirect.
REQ-011 SHALL have ports id_valid  output  1, id_instr  output  32, id_pc  output  32  instruction to decode.
REQ-012 SHALL have port id_ready  input  1  decode accepts.

Function
REQ-013 SHALL implement FSM states IDLE (no fetch outstanding), WAIT (one outstanding), DRAIN (outstanding fetch to be discarded).
REQ-014 SHALL drive imem_req=1 only in IDLE, with redirect_valid=0 and (queue count + outstanding) < QDEPTH.
REQ-015 SHALL drive imem_addr = {pc_cur[31:2],2'b00}.
REQ-016 On imem_req & imem_gnt SHALL pulse pc_en=1 with pc_next = pc_cur+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000), capture pc_cur as tag, IDLE->WAIT.
REQ-017 In WAIT, imem_rvalid SHALL push {imem_rdata, tag} into queue and go WAIT->IDLE; at most one fetch outstanding.
REQ-018 imem_req with imem_gnt=0 SHALL hold; pc_en=0, address stable, state IDLE.
REQ-019 redirect_valid=1 SHALL force pc_en=1, pc_next=redirect_pc, flush queue (count=0) in same edge; WAIT->DRAIN, IDLE stays IDLE, DRAIN stays DRAIN.
REQ-020 In DRAIN, imem_rvalid SHALL be discarded (no push), DRAIN->IDLE.
REQ-021 Redirect coinciding with imem_rvalid in WAIT SHALL discard the response and go to IDLE.
REQ-022 id_valid SHALL equal (count != 0), registered; id_instr/id_pc SHALL be the queue head.
REQ-023 id_valid & id_ready SHALL pop head; simultaneous push and pop SHALL keep count unchanged.
REQ-024 Redirect with id handshake in same cycle: flush wins; count=0 next cycle.
REQ-025 Minimum latency: grant at cycle N, rvalid at N+1, id_valid at N+2.
REQ-026 When neither grant nor redirect occurs, pc_en=0 and pc_next = pc_cur+4.
REQ-027 Pushes SHALL never overflow; credit rule of REQ-014 guarantees space; rvalid in IDLE is ignored.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, count=0, id_valid=0, imem_req=0, pc_en=0, queue pointers 0, tag 0.
REQ-029 Reset mid-fetch SHALL abandon the outstanding request; a later stray imem_rvalid in IDLE is ignored.
REQ-030 First imem_req SHALL assert in the first cycle after reset_n rises.

Configuration
REQ-031 Macro IF_FETCH_PERF_EN SHALL, when defined, add output fetch_stall_cnt (32 bits) counting cycles with id_ready=1 and id_valid=0, reset to 0, saturating at 0xFFFFFFFF.
REQ-032 Without IF_FETCH_PERF_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset release, pc_cur=0, gnt=1, rvalid one cycle later, id_ready=1 -> pc_next 0x4 with pc_en pulse; id_valid with id_pc=0x0 two cycles after grant; continuous stream of one instruction per two cycles.
REQ-034 id_ready=0, QDEPTH=2 -> after two fetches imem_req stays 0; one pop -> imem_req reasserts next cycle.
REQ-035 redirect_valid with redirect_pc=0x100 while in WAIT -> pc_next=0x100, queue empties, next rvalid dropped, next id_pc=0x100.
REQ-036 pc_cur=0xFFFFFFFC, grant -> pc_next=0x00000000; id_pc=0xFFFFFFFC.
REQ-037 reset_n low while WAIT, then rvalid after release -> no push, id_valid stays 0, new fetch from pc_cur.
REQ-038 With IF_FETCH_PERF_EN, hold id_ready=1 and gnt=0 for 10 cycles -> fetch_stall_cnt=10.
